// File: rtl/fp_mul_arbiter.sv
// Two-port round-robin arbiter in front of one shared multi-cycle FP multiplier, with a run watchdog.
// Define FP_MUL_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for port 0.
module fp_mul_arbiter #(
    parameter int MAXLAT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] x1,
    input  logic [31:0] y1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] z0,
    output logic [31:0] z1,
    output logic        err,
    output logic        busy,
    output logic        mul_ce,
    output logic        mul_run,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic        mul_stall,
    input  logic [31:0] mul_z
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mul_x_q, mul_x_d;
    logic [31:0] mul_y_q, mul_y_d;
    logic [31:0] z0_q, z0_d;
    logic [31:0] z1_q, z1_d;
    logic        err_q, err_d;
    logic        win1;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
    logic        last_q, last_d;
`endif

    // win1: port 1 takes this grant; last_q=1 means port 1 was served last
    always_comb begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        win1 = req1 & ~req0;
`else
        win1 = req1 & (~req0 | ~last_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        mul_x_d = mul_x_q;
        mul_y_d = mul_y_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        err_d   = err_q;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = win1;
                    mul_x_d = win1 ? x1 : x0;
                    mul_y_d = win1 ? y1 : y0;
                    cnt_d   = 8'd0;
                    state_d = RUN;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
                    last_d  = win1;
`endif
                end
            end
            RUN: begin
                if (!mul_stall) begin
                    if (gnt_q) z1_d = mul_z;
                    else       z0_d = mul_z;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 8'(MAXLAT - 1)) begin
                    // Multiplier never finished: report a zero result flagged by err
                    if (gnt_q) z1_d = 32'd0;
                    else       z0_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            cnt_q   <= 8'd0;
            mul_x_q <= 32'd0;
            mul_y_q <= 32'd0;
            z0_q    <= 32'd0;
            z1_q    <= 32'd0;
            err_q   <= 1'b0;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else if (ce) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            mul_x_q <= mul_x_d;
            mul_y_q <= mul_y_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            err_q   <= err_d;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign done0   = (state_q == DONE) & ~gnt_q;
    assign done1   = (state_q == DONE) &  gnt_q;
    assign busy    = (state_q != IDLE);
    assign mul_run = (state_q == RUN);
    assign mul_ce  = ce;
    assign mul_x   = mul_x_q;
    assign mul_y   = mul_y_q;
    assign z0      = z0_q;
    assign z1      = z1_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a 26-cycle multiplier stub driven by a product table.
// All stimulus is applied and all outputs are sampled on the falling clock edge.
module tb_fp_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        done0, done1, err, busy, mul_ce, mul_run;
    logic [31:0] z0, z1, mul_x, mul_y;
    logic        mul_stall;
    logic [31:0] mul_z;

    logic        stall_force = 1'b0;
    int          step;
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] P0 = 32'h40C0_0000; // 2.0 * 3.0
    localparam logic [31:0] P1 = 32'h4040_0000; // 1.5 * 2.0

    always #5 clk = ~clk;

    fp_mul_arbiter #(.MAXLAT(31)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .done0(done0), .done1(done1), .z0(z0), .z1(z1),
        .err(err), .busy(busy), .mul_ce(mul_ce), .mul_run(mul_run),
        .mul_x(mul_x), .mul_y(mul_y), .mul_stall(mul_stall), .mul_z(mul_z)
    );

    // Multiplier stub: result valid on the 26th enabled RUN cycle
    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h3F00_0000 && b == 32'h4100_0000) return 32'h4080_0000;
        if (a == 32'h0000_0000) return 32'h0000_0000;
        return 32'hDEAD_BEEF;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     step <= 0;
        else if (ce) step <= mul_run ? step + 1 : 0;
    end

    assign mul_stall = stall_force | ~(mul_run & (step == 25));
    assign mul_z     = prod(mul_x, mul_y);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int port, input int maxc, output int cyc);
        cyc = -1;
        for (int n = 1; n <= maxc; n++) begin
            tick();
            if ((port == 0) ? done0 : done1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ce = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tick();
        checks++; if ({busy, mul_run, done0, done1, err} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=00000", {busy, mul_run, done0, done1, err});
        end
        checks++; if ({z0, z1, mul_x, mul_y} !== 128'd0) begin
            failures++; $display("FAIL reset_data got=%h want=0", {z0, z1, mul_x, mul_y});
        end
        checks++; if (mul_ce !== 1'b1) begin
            failures++; $display("FAIL reset_mul_ce got=%b want=1", mul_ce);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int c;
        x0 = 32'h4000_0000; y0 = 32'h4040_0000; req0 = 1'b1;
        tick();
        checks++; if ({mul_run, busy, mul_x, mul_y} !== {2'b11, 32'h4000_0000, 32'h4040_0000}) begin
            failures++; $display("FAIL basic_grant got=%b%b %h %h want=11 40000000 40400000", mul_run, busy, mul_x, mul_y);
        end
        req0 = 1'b0; x0 = 32'h1234_5678; y0 = 32'h9ABC_DEF0;
        wait_done(0, 40, c);
        checks++; if (c + 1 !== 27) begin
            failures++; $display("FAIL basic_latency got=%0d want=27", c + 1);
        end
        checks++; if ({z0, err, mul_run} !== {P0, 2'b00}) begin
            failures++; $display("FAIL basic_result got=%h err=%b run=%b want=40c00000 0 0", z0, err, mul_run);
        end
        tick();
        checks++; if ({done0, busy} !== 2'b00) begin
            failures++; $display("FAIL basic_one_pulse got=%b want=00", {done0, busy});
        end
    endtask

    task automatic test_round_robin();
        int c;
        int second;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        second = 0;
`else
        second = 1;
`endif
        do_reset();
        x0 = 32'h4000_0000; y0 = 32'h4040_0000;
        x1 = 32'h3FC0_0000; y1 = 32'h4000_0000;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(0, 40, c);
        checks++; if (c !== 27) begin
            failures++; $display("FAIL rr_first_latency got=%0d want=27", c);
        end
        checks++; if ({z0, done1} !== {P0, 1'b0}) begin
            failures++; $display("FAIL rr_first_result got=%h done1=%b want=40c00000 0", z0, done1);
        end
        tick();
        tick();
        checks++; if (mul_x !== ((second == 1) ? x1 : x0)) begin
            failures++; $display("FAIL rr_second_grant got=%h want=%h", mul_x, (second == 1) ? x1 : x0);
        end
        if (second == 1) req0 = 1'b0; else req1 = 1'b0;
        wait_done(second, 40, c);
        checks++; if (c + 29 !== 55) begin
            failures++; $display("FAIL rr_second_latency got=%0d want=55", c + 29);
        end
        checks++; if ({z0, ((second == 1) ? z1 : 32'd0)} !== {P0, ((second == 1) ? P1 : 32'd0)}) begin
            failures++; $display("FAIL rr_second_result got z0=%h z1=%h", z0, z1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int c;
        logic [31:0] z0_keep;
        z0_keep = z0;
        stall_force = 1'b1;
        x1 = 32'h3FC0_0000; y1 = 32'h4000_0000; req1 = 1'b1;
        wait_done(1, 50, c);
        req1 = 1'b0;
        checks++; if (c !== 32) begin
            failures++; $display("FAIL wd_latency got=%0d want=32", c);
        end
        checks++; if ({err, z1, z0} !== {1'b1, 32'd0, z0_keep}) begin
            failures++; $display("FAIL wd_result got err=%b z1=%h z0=%h want 1 0 %h", err, z1, z0, z0_keep);
        end
        stall_force = 1'b0;
        tick();
        checks++; if ({err, busy, done1} !== 3'b100) begin
            failures++; $display("FAIL wd_err_hold got=%b want=100", {err, busy, done1});
        end
    endtask

    task automatic test_zero_and_reset();
        int c;
        int pulses;
        x0 = 32'h0000_0000; y0 = 32'h4040_0000; req0 = 1'b1;
        wait_done(0, 40, c);
        req0 = 1'b0;
        checks++; if ({c, z0, err} !== {32'd27, 32'd0, 1'b0}) begin
            failures++; $display("FAIL zero_op got cyc=%0d z0=%h err=%b want 27 0 0", c, z0, err);
        end
        tick();
        x0 = 32'h4000_0000; y0 = 32'h4040_0000; req0 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if ({busy, mul_run, mul_x} !== {2'b11, 32'h4000_0000}) begin
            failures++; $display("FAIL rst_pre got=%b%b %h want=11 40000000", busy, mul_run, mul_x);
        end
        rst = 1'b1; req0 = 1'b0;
        #1;
        checks++; if ({busy, mul_run, done0, done1, err, mul_x, mul_y} !== 69'd0) begin
            failures++; $display("FAIL rst_async got=%b%b%b%b%b %h %h want all 0", busy, mul_run, done0, done1, err, mul_x, mul_y);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done0 | done1 | busy) pulses++;
        end
        checks++; if (pulses !== 0) begin
            failures++; $display("FAIL rst_no_done got=%0d want=0", pulses);
        end
        req0 = 1'b1;
        wait_done(0, 40, c);
        req0 = 1'b0;
        checks++; if ({c, z0, err} !== {32'd27, P0, 1'b0}) begin
            failures++; $display("FAIL rst_recover got cyc=%0d z0=%h err=%b want 27 40c00000 0", c, z0, err);
        end
        tick();
    endtask

    task automatic test_ce_toggle();
        int hi;
        logic seen;
        do_reset();
        x0 = 32'h3F00_0000; y0 = 32'h4100_0000; req0 = 1'b1; ce = 1'b1;
        hi = 0; seen = 1'b0;
        for (int n = 0; n < 120; n++) begin
            @(posedge clk);
            if (ce) hi++;
            @(negedge clk);
            if (hi == 1) req0 = 1'b0;
            if (done0) begin
                seen = 1'b1;
                break;
            end
            ce = ~ce;
        end
        checks++; if ({seen, hi} !== {1'b1, 32'd27}) begin
            failures++; $display("FAIL ce_latency got seen=%b hi=%0d want 1 27", seen, hi);
        end
        ce = 1'b0;
        tick();
        checks++; if ({done0, z0, mul_ce} !== {1'b1, 32'h4080_0000, 1'b0}) begin
            failures++; $display("FAIL ce_hold got done0=%b z0=%h mul_ce=%b want 1 40800000 0", done0, z0, mul_ce);
        end
        ce = 1'b1;
        tick();
        checks++; if ({done0, busy} !== 2'b00) begin
            failures++; $display("FAIL ce_release got=%b want=00", {done0, busy});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_watchdog();
        test_zero_and_reset();
        test_ce_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
